// File: rtl/score_display.sv
// Four-digit multiplexed seven-segment score display: snapshots the score once per
// frame, then scans the digits with an all-off guard interval before each one.
module score_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic [31:0] ones_d,
  input  logic [31:0] tens_d,
  input  logic [31:0] hundreds_d,
  input  logic [31:0] thousands_d,
  input  logic        blank_lz,
  input  logic        freeze,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        snap_valid,
  output logic        overflow
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  typedef enum logic [1:0] {
    ST_CAPTURE,
    ST_GUARD,
    ST_DRIVE
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       idx_reg, idx_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             snap_valid_reg;
  logic             overflow_reg;
  logic             blank_lz_reg;
  logic             capture_en;

  logic [3:0][31:0] din;
  logic [3:0]       in_over;
  logic [3:0]       is_zero;
  logic [3:0]       is_over;
  logic [3:0]       blank_mask;
  logic [3:0][6:0]  seg_dig;

  assign din        = {thousands_d, hundreds_d, tens_d, ones_d};
  assign capture_en = (state_reg == ST_CAPTURE) && !freeze;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  // One snapshot register and decoder per digit; gi=0 is ones, gi=3 is thousands.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic [31:0] snap_reg;

      always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
          snap_reg <= '0;
        end else if (capture_en) begin
          snap_reg <= din[gi];
        end
      end

      assign in_over[gi] = din[gi] > 32'd9;
      assign is_zero[gi] = snap_reg == 32'd0;
      assign is_over[gi] = snap_reg > 32'd9;
      assign seg_dig[gi] = blank_mask[gi] ? SEG_OFF :
                           is_over[gi]    ? SEG_DASH :
                                            digit_seg(snap_reg[3:0]);
    end
  endgenerate

  // A digit is blanked only when it and every more significant digit are zero.
  assign blank_mask[3] = blank_lz_reg & is_zero[3];
  assign blank_mask[2] = blank_lz_reg & is_zero[3] & is_zero[2];
  assign blank_mask[1] = blank_lz_reg & is_zero[3] & is_zero[2] & is_zero[1];
  assign blank_mask[0] = 1'b0;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_CAPTURE: begin
        idx_next   = 2'd0;
        cnt_next   = '0;
        state_next = ST_GUARD;
      end
      ST_GUARD: begin
        if (cnt_reg == GUARD_LAST) begin
          cnt_next   = '0;
          state_next = ST_DRIVE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_DRIVE: begin
        if (cnt_reg == DRIVE_LAST) begin
          cnt_next = '0;
          if (idx_reg == 2'd3) begin
            state_next = ST_CAPTURE;
          end else begin
            idx_next   = idx_reg + 2'd1;
            state_next = ST_GUARD;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        idx_next   = 2'd0;
        cnt_next   = '0;
        state_next = ST_CAPTURE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state_reg      <= ST_CAPTURE;
      idx_reg        <= 2'd0;
      cnt_reg        <= '0;
      snap_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      blank_lz_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      cnt_reg        <= cnt_next;
      snap_valid_reg <= capture_en;
      blank_lz_reg   <= blank_lz;
      if (capture_en) begin
        overflow_reg <= |in_over;
      end
    end
  end

  // Outputs depend on registered state only, so reset blanks them without a clock.
  always_comb begin
    seg = SEG_OFF;
    an  = 4'b1111;
    if (state_reg == ST_DRIVE) begin
      an  = ~(4'b0001 << idx_reg);
      seg = seg_dig[idx_reg];
    end
  end

  assign snap_valid = snap_valid_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display (REFRESH_DIV=4, BLANK_CYC=2, 25-cycle frame).
module tb_score_display;

  logic        clock;
  logic        ctrl_reset;
  logic [31:0] ones_d, tens_d, hundreds_d, thousands_d;
  logic        blank_lz, freeze;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        snap_valid, overflow;

  int n_checks = 0;
  int n_fail   = 0;

  score_display #(.REFRESH_DIV(4), .BLANK_CYC(2)) dut (
    .clock       (clock),
    .ctrl_reset  (ctrl_reset),
    .ones_d      (ones_d),
    .tens_d      (tens_d),
    .hundreds_d  (hundreds_d),
    .thousands_d (thousands_d),
    .blank_lz    (blank_lz),
    .freeze      (freeze),
    .seg         (seg),
    .an          (an),
    .snap_valid  (snap_valid),
    .overflow    (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] th, hu, te, on;
    logic        blz;
    logic [6:0]  s0, s1, s2, s3;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  localparam logic [6:0] OFF = 7'b1111111;

  vec_t vecs[11];
  exp_t sb[$];
  exp_t mon_e;

  // Scoreboard consumer: one expected {an,seg} per cycle while entries are pending.
  always @(posedge clock) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_checks++;
      if (an !== mon_e.an || seg !== mon_e.seg) begin
        n_fail++;
        $display("FAIL frame_cycle: an=%b seg=%b required an=%b seg=%b",
                 an, seg, mon_e.an, mon_e.seg);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait expired", nm);
  endtask

  task automatic wait_sv_high(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clock);
      if (snap_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clock);
      if (sb.size() == 0) ok = 1'b1;
    end
  endtask

  task automatic wait_an(input logic [3:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clock);
      if (an === target) ok = 1'b1;
    end
  endtask

  // Called in the first GUARD cycle; covers the rest of the frame up to CAPTURE.
  task automatic push_frame(input logic [6:0] s0, s1, s2, s3);
    logic [6:0] s;
    logic [3:0] a;
    sb.push_back('{4'b1111, OFF});
    for (int d = 0; d < 4; d++) begin
      s = (d == 0) ? s0 : (d == 1) ? s1 : (d == 2) ? s2 : s3;
      a = ~(4'b0001 << d);
      if (d > 0) begin
        sb.push_back('{4'b1111, OFF});
        sb.push_back('{4'b1111, OFF});
      end
      for (int c = 0; c < 4; c++) sb.push_back('{a, s});
    end
  endtask

  task automatic apply_vector(input int k);
    bit ok;
    wait_drain(ok);
    if (!ok) timeout_fail("drain");
    thousands_d = vecs[k].th;
    hundreds_d  = vecs[k].hu;
    tens_d      = vecs[k].te;
    ones_d      = vecs[k].on;
    blank_lz    = vecs[k].blz;
    freeze      = 1'b0;
    wait_sv_high(ok);
    if (!ok) begin
      timeout_fail("snap_valid_wait");
      return;
    end
    $display("vector %0d: th=%0h hu=%0h te=%0h on=%0h blank_lz=%0b",
             k, vecs[k].th, vecs[k].hu, vecs[k].te, vecs[k].on, vecs[k].blz);
    chk("overflow", {31'd0, overflow}, {31'd0, vecs[k].ovf});
    push_frame(vecs[k].s0, vecs[k].s1, vecs[k].s2, vecs[k].s3);
    // Mid-frame input changes must not disturb the frame just captured.
    thousands_d = $urandom;
    hundreds_d  = $urandom;
    tens_d      = $urandom;
    ones_d      = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int k;
    int t0;
    logic [6:0] fe;

    //             th            hu     te      on             blz  s0(ones)    s1(tens)    s2(hund)    s3(thou)    ovf
    vecs[0]  = '{32'd1,        32'd2, 32'd3,  32'd4,         1'b0, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 1'b0};
    vecs[1]  = '{32'd0,        32'd0, 32'd0,  32'd0,         1'b1, 7'b1000000, OFF,        OFF,        OFF,        1'b0};
    vecs[2]  = '{32'd0,        32'd5, 32'd0,  32'd7,         1'b1, 7'b1111000, 7'b1000000, 7'b0010010, OFF,        1'b0};
    vecs[3]  = '{32'd0,        32'd0, 32'd12, 32'd0,         1'b0, 7'b1000000, 7'b0111111, 7'b1000000, 7'b1000000, 1'b1};
    vecs[4]  = '{32'd0,        32'd0, 32'd3,  32'd0,         1'b0, 7'b1000000, 7'b0110000, 7'b1000000, 7'b1000000, 1'b0};
    vecs[5]  = '{32'd6,        32'd8, 32'd9,  32'd0,         1'b1, 7'b1000000, 7'b0010000, 7'b0000000, 7'b0000010, 1'b0};
    vecs[6]  = '{32'd0,        32'd0, 32'd12, 32'd0,         1'b1, 7'b1000000, 7'b0111111, OFF,        OFF,        1'b1};
    vecs[7]  = '{32'd9,        32'd9, 32'd9,  32'd9,         1'b0, 7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000, 1'b0};
    vecs[8]  = '{32'd0,        32'd0, 32'd0,  32'h8000_0000, 1'b1, 7'b0111111, OFF,        OFF,        OFF,        1'b1};
    vecs[9]  = '{32'd3,        32'd0, 32'd0,  32'd1,         1'b1, 7'b1111001, 7'b1000000, 7'b1000000, 7'b0110000, 1'b0};
    vecs[10] = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0,         1'b1, 7'b1000000, 7'b1000000, 7'b1000000, 7'b0111111, 1'b1};

    // Reset and first capture
    ctrl_reset  = 1'b0;
    thousands_d = 32'd1;
    hundreds_d  = 32'd2;
    tens_d      = 32'd3;
    ones_d      = 32'd4;
    blank_lz    = 1'b0;
    freeze      = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_an", {28'd0, an}, 32'hF);
    chk("reset_seg", {25'd0, seg}, {25'd0, OFF});
    chk("reset_snap_valid", {31'd0, snap_valid}, 32'd0);
    chk("reset_overflow", {31'd0, overflow}, 32'd0);
    ctrl_reset = 1'b1;
    @(negedge clock);
    chk("first_snap_valid", {31'd0, snap_valid}, 32'd1);
    chk("first_guard0_an", {28'd0, an}, 32'hF);
    @(negedge clock);
    chk("first_snap_valid_drop", {31'd0, snap_valid}, 32'd0);
    chk("first_guard1_an", {28'd0, an}, 32'hF);
    @(negedge clock);
    chk("first_drive_an", {28'd0, an}, 32'hE);
    chk("first_drive_seg", {25'd0, seg}, 32'b0011001);
    $display("reset sequence: first capture observed");

    // Frame period between snap_valid pulses
    t0 = 1;
    k  = 3;
    ok = 1'b0;
    while (!ok && k < 80) begin
      @(negedge clock);
      k++;
      if (snap_valid === 1'b1) ok = 1'b1;
    end
    if (ok) chk("snap_valid_period", k - t0, 32'd25);
    else timeout_fail("snap_valid_period");
    $display("period sequence: snap_valid interval %0d", k - t0);

    // blank_lz toggles on the very next cycle, without a new capture
    thousands_d = 32'd0;
    hundreds_d  = 32'd0;
    tens_d      = 32'd0;
    ones_d      = 32'd0;
    blank_lz    = 1'b1;
    wait_sv_high(ok);
    if (!ok) timeout_fail("blz_capture");
    wait_an(4'b0111, ok);
    if (!ok) timeout_fail("blz_an_wait");
    chk("blz_on_thousands", {25'd0, seg}, {25'd0, OFF});
    blank_lz = 1'b0;
    @(negedge clock);
    chk("blz_off_thousands", {25'd0, seg}, 32'b1000000);
    chk("blz_off_an", {28'd0, an}, 32'h7);
    $display("blank toggle sequence: done");

    for (int i = 0; i < 11; i++) apply_vector(i);

    // Freeze: 1234 stays up for three frames while inputs read 9999
    apply_vector(0);
    freeze      = 1'b1;
    thousands_d = 32'd9;
    hundreds_d  = 32'd9;
    tens_d      = 32'd9;
    ones_d      = 32'd9;
    for (int c = 0; c < 75; c++) begin
      @(negedge clock);
      chk("freeze_snap_valid", {31'd0, snap_valid}, 32'd0);
      case (an)
        4'b1111: fe = OFF;
        4'b1110: fe = 7'b0011001;
        4'b1101: fe = 7'b0110000;
        4'b1011: fe = 7'b0100100;
        4'b0111: fe = 7'b1111001;
        default: fe = 7'bxxxxxxx;
      endcase
      if (fe === 7'bxxxxxxx) begin
        n_checks++;
        n_fail++;
        $display("FAIL freeze_an: got %b required one-hot-low or 1111", an);
      end else begin
        chk("freeze_seg", {25'd0, seg}, {25'd0, fe});
      end
    end
    $display("freeze sequence: 75 cycles held");
    apply_vector(7);

    // Mid-frame asynchronous reset while digit 2 is driven
    apply_vector(10);
    sb.delete();
    wait_an(4'b1011, ok);
    if (!ok) timeout_fail("midreset_an_wait");
    #2 ctrl_reset = 1'b0;
    #1;
    chk("midreset_an", {28'd0, an}, 32'hF);
    chk("midreset_seg", {25'd0, seg}, {25'd0, OFF});
    chk("midreset_snap_valid", {31'd0, snap_valid}, 32'd0);
    chk("midreset_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    ctrl_reset = 1'b1;
    @(negedge clock);
    chk("restart_snap_valid", {31'd0, snap_valid}, 32'd1);
    chk("restart_guard0_an", {28'd0, an}, 32'hF);
    @(negedge clock);
    chk("restart_guard1_an", {28'd0, an}, 32'hF);
    @(negedge clock);
    chk("restart_drive_idx0", {28'd0, an}, 32'hE);
    $display("mid-frame reset sequence: restart observed");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
